// File: rtl/moore_stream_pkg.sv
// moore_stream_pkg
//   Shared types and constants for the bit serializer that feeds the Moore
//   sequence detector's serial input.
//   - state_e      : serializer FSM encoding (IDLE / SHIFT / PARITY)
//   - CNT_W        : bit-counter width for the default 5-bit word
//   - cnt_width()  : bit-counter width for any word width, $clog2(width+1)
//   - J_IDLE       : level driven on j while no frame is in flight
package moore_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int   WIDTH_DEFAULT = 5;
    localparam int   CNT_W         = $clog2(WIDTH_DEFAULT + 1);
    localparam logic J_IDLE        = 1'b0;

    // The counter must hold the value WIDTH itself, hence width+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/moore_bit_serializer_piso.sv
// piso_shift_reg
//   Load/shift register that holds the bits of a word still waiting to go out.
//   The first bit of a word is emitted straight from din at load time, so only
//   WIDTH-1 bits are stored here.
// Ports
//   clk, rst   : clock, synchronous active-high reset (clears the register)
//   load       : capture the remaining bits of din (has priority over shift)
//   shift      : advance the register by one bit, zero-filling
//   din        : parallel word
//   first_bit  : bit of din that is transmitted first (combinational from din)
//   next_bit   : bit currently at the head of the stored remainder
// Parameters
//   WIDTH      : word width (>= 2)
//   MSB_FIRST  : 1 = din[WIDTH-1] first, 0 = din[0] first
module piso_shift_reg #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             first_bit,
    output logic             next_bit
);

    localparam int REM = WIDTH - 1;

    logic [REM-1:0] rem_reg;
    logic [REM-1:0] rem_load;
    logic [REM-1:0] rem_shifted;

    genvar gi;
    generate
        if (MSB_FIRST) begin : g_msb
            assign first_bit = din[WIDTH-1];
            assign next_bit  = rem_reg[REM-1];
            for (gi = 0; gi < REM; gi++) begin : g_bit
                assign rem_load[gi] = din[gi];
                if (gi == 0) begin : g_fill
                    assign rem_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign rem_shifted[gi] = rem_reg[gi-1];
                end
            end
        end else begin : g_lsb
            assign first_bit = din[0];
            assign next_bit  = rem_reg[0];
            for (gi = 0; gi < REM; gi++) begin : g_bit
                assign rem_load[gi] = din[gi+1];
                if (gi == REM - 1) begin : g_fill
                    assign rem_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign rem_shifted[gi] = rem_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg <= '0;
        end else if (load) begin
            rem_reg <= rem_load;
        end else if (shift) begin
            rem_reg <= rem_shifted;
        end
    end

endmodule

// File: rtl/moore_bit_serializer.sv
// moore_bit_serializer
//   Parallel-in / serial-out stage feeding the Moore 10010 detector input j.
//   Accepts WIDTH-bit words on a valid/ready handshake and sends one bit per
//   clock, first bit in the cycle after accept, with gapless back-to-back
//   frames. j idles at 0.
// Optional feature (macro SERIAL_PARITY_EN): appends one even-parity bit
//   (^din) per frame; done and din_ready then move to that parity cycle.
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; abandons any frame
//   din        : word to serialize (held stable by the producer until accepted)
//   din_valid  : din is valid
//   din_ready  : word accepted when din_valid & din_ready
//   j          : serial bit (registered)
//   j_valid    : j carries a frame bit (registered)
//   busy       : frame in progress
//   done       : pulse on the last bit of a frame
module moore_bit_serializer #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             j,
    output logic             j_valid,
    output logic             busy,
    output logic             done
);

    import moore_stream_pkg::*;

    localparam int         CNT_BITS  = cnt_width(WIDTH);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SHIFT  = SHIFT;
`ifdef SERIAL_PARITY_EN
    localparam logic [1:0] ST_PARITY = PARITY;
`endif

    logic [1:0]          state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic                j_reg, j_next;
    logic                j_valid_reg, j_valid_next;
    logic                load, shift, first_bit, next_bit;
    logic                last_cycle, accept;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .din       (din),
        .first_bit (first_bit),
        .next_bit  (next_bit)
    );

`ifdef SERIAL_PARITY_EN
    logic parity_reg;

    // Parity of the whole word is captured at accept; din may change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^din;
        end
    end

    assign last_cycle = (state_reg == ST_PARITY);
`else
    assign last_cycle = (state_reg == ST_SHIFT) && (cnt_reg == CNT_BITS'(1));
`endif

    assign din_ready = (state_reg == ST_IDLE) || last_cycle;
    assign accept    = din_valid && din_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = last_cycle;
    assign j         = j_reg;
    assign j_valid   = j_valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        j_next     = J_IDLE;
        load       = 1'b0;
        shift      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_reg != CNT_BITS'(1)) begin
                    shift    = 1'b1;
                    cnt_next = cnt_reg - CNT_BITS'(1);
                    j_next   = next_bit;
                end else begin
                    cnt_next = '0;
`ifdef SERIAL_PARITY_EN
                    state_next = ST_PARITY;
                    j_next     = parity_reg;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: begin
                state_next = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Accept is only possible when idle or on the last frame cycle, so it
        // simply overrides whatever the case above chose: this gives the
        // gapless reload on back-to-back words.
        if (accept) begin
            load       = 1'b1;
            cnt_next   = CNT_BITS'(WIDTH);
            j_next     = first_bit;
            state_next = ST_SHIFT;
        end

        j_valid_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            j_reg       <= J_IDLE;
            j_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            j_reg       <= j_next;
            j_valid_reg <= j_valid_next;
        end
    end

endmodule
